pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 24 ++
 rtl/ras_stack.sv | 65 ++++++
 rtl/pc_gen.sv | 105 ++++++++++
 tb/tb_pc_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-PC generator: next-PC selector encodings,
// default reset/exception vectors and a saturating counter helper.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'b000,
        NPC_BRANCH = 3'b001,
        NPC_JUMP   = 3'b010,
        NPC_JR     = 3'b011,
        NPC_ERET   = 3'b100
    } npc_op_e;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_ENTRY = 32'h0000_4180;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop on empty is ignored, and push+pop together replaces the top entry.
module ras_stack #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_r [RAS_DEPTH];
    logic [PW-1:0]    ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [PW-1:0]    top_idx_s;
    logic             empty_s;

    assign top_idx_s = ptr_r - PW'(1);
    assign empty_s   = (cnt_r == '0);

    // Stack storage, write pointer and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r <= '0;
            cnt_r <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            ptr_r <= '0;
            cnt_r <= '0;
        end else if (push && pop && !empty_s) begin
            mem_r[top_idx_s] <= din;
        end else if (push) begin
            mem_r[ptr_r] <= din;
            ptr_r        <= ptr_r + PW'(1);
            if (cnt_r != FULL_CNT) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else if (pop && !empty_s) begin
            ptr_r <= top_idx_s;
            cnt_r <= cnt_r - CW'(1);
        end
    end

    // Top-of-stack view; zero while empty so no stale entry leaks out.
    always_comb begin
        empty = empty_s;
        if (empty_s) begin
            top = '0;
        end else begin
            top = mem_r[top_idx_s];
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: selects the next fetch address from sequential, branch,
// jump, jr and eret sources, and tracks return prediction with a RAS.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [WIDTH-1:0] EXC_ENTRY = DEF_EXC_ENTRY,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       npc_op,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] d_pc,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] epc,
    input  logic             link,
    input  logic             is_ret,
    output logic [WIDTH-1:0] f_pc,
    output logic [WIDTH-1:0] pc_4,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_empty,
    output logic [15:0]      ret_miss_cnt
);

    npc_op_e          op_s;
    logic [WIDTH-1:0] f_pc_r;
    logic [WIDTH-1:0] next_pc_s;
    logic [WIDTH-1:0] seq_pc_s;
    logic [WIDTH-1:0] br_pc_s;
    logic [WIDTH-1:0] j_pc_s;
    logic             push_s;
    logic             pop_s;
    logic             miss_s;
    logic [15:0]      miss_cnt_r;

    assign op_s     = npc_op_e'(npc_op);
    assign seq_pc_s = f_pc_r + WIDTH'(4);
    assign br_pc_s  = d_pc + WIDTH'(4) + {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
    assign j_pc_s   = {d_pc[WIDTH-1:28], imm26, 2'b00};

    // Exceptions squash any stack update in the same cycle.
    assign push_s = link && !stall && !exc_req;
    assign pop_s  = (op_s == NPC_JR) && is_ret && !stall && !exc_req;
    assign miss_s = ras_empty || (ras_top != ra);

    // Next-PC priority: exception, eret, stall hold, then the selector.
    always_comb begin
        next_pc_s = seq_pc_s;
        if (exc_req) begin
            next_pc_s = EXC_ENTRY;
        end else if (op_s == NPC_ERET) begin
            next_pc_s = epc;
        end else if (stall) begin
            next_pc_s = f_pc_r;
        end else begin
            case (op_s)
                NPC_BRANCH: next_pc_s = br_pc_s;
                NPC_JUMP:   next_pc_s = j_pc_s;
                NPC_JR:     next_pc_s = ra;
                default:    next_pc_s = seq_pc_s;
            endcase
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            f_pc_r <= RESET_PC;
        end else begin
            f_pc_r <= next_pc_s;
        end
    end

    // Return-mispredict counter, saturating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            miss_cnt_r <= '0;
        end else if (pop_s && miss_s) begin
            miss_cnt_r <= sat_inc16(miss_cnt_r);
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (exc_req),
        .din   (d_pc + WIDTH'(8)),
        .top   (ras_top),
        .empty (ras_empty)
    );

    assign f_pc         = f_pc_r;
    assign pc_4         = f_pc_r + WIDTH'(4);
    assign ret_miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed table, multi-cycle RAS sequences
// and a randomized run against a queue-based reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_op;
    logic        exc_req;
    logic [31:0] d_pc;
    logic [25:0] imm26;
    logic [31:0] ra;
    logic [31:0] epc;
    logic        link;
    logic        is_ret;
    logic [31:0] f_pc;
    logic [31:0] pc_4;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic [15:0] ret_miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .npc_op       (npc_op),
        .exc_req      (exc_req),
        .d_pc         (d_pc),
        .imm26        (imm26),
        .ra           (ra),
        .epc          (epc),
        .link         (link),
        .is_ret       (is_ret),
        .f_pc         (f_pc),
        .pc_4         (pc_4),
        .ras_top      (ras_top),
        .ras_empty    (ras_empty),
        .ret_miss_cnt (ret_miss_cnt)
    );

    typedef struct {
        logic [2:0]  op;
        logic        exc;
        logic        stl;
        logic        lnk;
        logic [31:0] dpc;
        logic [25:0] imm;
        logic [31:0] ep;
        logic [31:0] exp_pc;
        logic        exp_empty;
    } vec_t;

    vec_t vecs[10];

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic [15:0] m_miss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; stall = 1'b0; npc_op = 3'd0; exc_req = 1'b0;
        d_pc = 32'h0; imm26 = 26'h0; ra = 32'h0; epc = 32'h0;
        link = 1'b0; is_ret = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // Reference: apply one clock edge's worth of the architectural rules.
    task automatic model_step();
        logic do_push, do_pop;
        if (!reset) begin
            m_pc = 32'h0000_3000;
            m_q.delete();
            m_miss = 16'h0;
        end else begin
            do_push = link && !stall && !exc_req;
            do_pop  = (npc_op == 3'd3) && is_ret && !stall && !exc_req;
            if (do_pop && (m_q.size() == 0 || m_q[$] != ra) && m_miss != 16'hFFFF)
                m_miss = m_miss + 16'd1;
            if (exc_req) begin
                m_q.delete();
            end else if (do_push && do_pop && m_q.size() > 0) begin
                m_q[$] = d_pc + 32'd8;
            end else if (do_push) begin
                m_q.push_back(d_pc + 32'd8);
                if (m_q.size() > 4) void'(m_q.pop_front());
            end else if (do_pop && m_q.size() > 0) begin
                void'(m_q.pop_back());
            end
            if (exc_req) m_pc = 32'h0000_4180;
            else if (npc_op == 3'd4) m_pc = epc;
            else if (stall) m_pc = m_pc;
            else if (npc_op == 3'd1) m_pc = d_pc + 32'd4 + 32'(int'($signed(imm26[15:0])) * 4);
            else if (npc_op == 3'd2) m_pc = (d_pc & 32'hF000_0000) | ({6'd0, imm26} * 32'd4);
            else if (npc_op == 3'd3) m_pc = ra;
            else m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        logic [31:0] exp_tops[4];
        idle();
        reset = 1'b0;

        vecs[0] = '{3'd0, 1'b0, 1'b0, 1'b0, 32'h0,    26'h0,     32'h0,    32'h3004, 1'b1};
        vecs[1] = '{3'd0, 1'b0, 1'b0, 1'b0, 32'h0,    26'h0,     32'h0,    32'h3008, 1'b1};
        vecs[2] = '{3'd0, 1'b0, 1'b0, 1'b0, 32'h0,    26'h0,     32'h0,    32'h300C, 1'b1};
        vecs[3] = '{3'd1, 1'b0, 1'b0, 1'b0, 32'h3010, 26'hFFFE,  32'h0,    32'h300C, 1'b1};
        vecs[4] = '{3'd2, 1'b0, 1'b0, 1'b0, 32'h3010, 26'h0C10,  32'h0,    32'h3040, 1'b1};
        vecs[5] = '{3'd0, 1'b0, 1'b0, 1'b1, 32'h3040, 26'h0,     32'h0,    32'h3044, 1'b0};
        vecs[6] = '{3'd1, 1'b1, 1'b1, 1'b0, 32'h3010, 26'h4,     32'h0,    32'h4180, 1'b1};
        vecs[7] = '{3'd4, 1'b0, 1'b0, 1'b0, 32'h0,    26'h0,     32'h3020, 32'h3020, 1'b1};
        vecs[8] = '{3'd0, 1'b0, 1'b1, 1'b0, 32'h0,    26'h0,     32'h0,    32'h3020, 1'b1};
        vecs[9] = '{3'd4, 1'b0, 1'b1, 1'b0, 32'h0,    26'h0,     32'h3100, 32'h3100, 1'b1};

        // reset state
        tick();
        tick();
        reset = 1'b1;
        check("reset_f_pc", f_pc, 32'h3000);
        check("reset_pc_4", pc_4, 32'h3004);
        check("reset_empty", {31'd0, ras_empty}, 32'd1);
        check("reset_top", ras_top, 32'h0);
        check("reset_miss", {16'd0, ret_miss_cnt}, 32'h0);

        // directed table
        for (int i = 0; i < 10; i++) begin
            npc_op = vecs[i].op; exc_req = vecs[i].exc; stall = vecs[i].stl;
            link = vecs[i].lnk; d_pc = vecs[i].dpc; imm26 = vecs[i].imm; epc = vecs[i].ep;
            tick();
            check($sformatf("vec%0d_f_pc", i), f_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_empty", i), {31'd0, ras_empty}, {31'd0, vecs[i].exp_empty});
        end

        // five pushes into a depth-4 stack, then drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            link = 1'b1; d_pc = 32'h3000 + 32'(i * 4);
            tick();
        end
        link = 1'b0;
        exp_tops[0] = 32'h3018; exp_tops[1] = 32'h3014;
        exp_tops[2] = 32'h3010; exp_tops[3] = 32'h300C;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ras_top_pop%0d", i), ras_top, exp_tops[i]);
            npc_op = 3'd3; is_ret = 1'b1; ra = exp_tops[i];
            tick();
        end
        check("drain_empty", {31'd0, ras_empty}, 32'd1);
        check("drain_miss0", {16'd0, ret_miss_cnt}, 32'd0);
        ra = 32'h3008;
        tick();
        check("empty_pop_miss", {16'd0, ret_miss_cnt}, 32'd1);
        check("empty_pop_top", ras_top, 32'h0);

        // simultaneous push and pop replaces the top
        do_reset();
        link = 1'b1; d_pc = 32'h3000;
        tick();
        npc_op = 3'd3; is_ret = 1'b1; ra = 32'h3008; d_pc = 32'h3100;
        tick();
        check("pushpop_top", ras_top, 32'h3108);
        check("pushpop_miss", {16'd0, ret_miss_cnt}, 32'd0);
        link = 1'b0; ra = 32'h3108;
        tick();
        check("pushpop_count", {31'd0, ras_empty}, 32'd1);

        // saturation of the miss counter
        ra = 32'h0;
        for (int i = 0; i < 65535; i++) tick();
        check("miss_sat", {16'd0, ret_miss_cnt}, 32'hFFFF);
        tick(); tick(); tick();
        check("miss_hold", {16'd0, ret_miss_cnt}, 32'hFFFF);

        // reset while stalled with a non-empty stack
        npc_op = 3'd0; is_ret = 1'b0; link = 1'b1; d_pc = 32'h5000;
        tick();
        check("pre_rst_nonempty", {31'd0, ras_empty}, 32'd0);
        link = 1'b0; stall = 1'b1; reset = 1'b0;
        tick();
        check("stall_rst_f_pc", f_pc, 32'h3000);
        check("stall_rst_empty", {31'd0, ras_empty}, 32'd1);
        check("stall_rst_miss", {16'd0, ret_miss_cnt}, 32'd0);
        check("stall_rst_top", ras_top, 32'h0);

        // randomized run against the reference model
        idle();
        reset = 1'b0;
        model_step();
        tick();
        for (int n = 0; n < 2000; n++) begin
            reset   = ($urandom_range(0, 63) != 0);
            stall   = ($urandom_range(0, 3) == 0);
            exc_req = ($urandom_range(0, 15) == 0);
            npc_op  = 3'($urandom_range(0, 7));
            link    = ($urandom_range(0, 3) == 0);
            is_ret  = ($urandom_range(0, 1) == 1);
            d_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            imm26   = 26'($urandom);
            epc     = $urandom;
            if ($urandom_range(0, 1) == 1 && m_q.size() > 0) ra = m_q[$];
            else ra = $urandom;
            model_step();
            tick();
            check("rnd_f_pc", f_pc, m_pc);
            check("rnd_pc_4", pc_4, m_pc + 32'd4);
            check("rnd_top", ras_top, (m_q.size() > 0) ? m_q[$] : 32'h0);
            check("rnd_empty", {31'd0, ras_empty}, {31'd0, (m_q.size() == 0)});
            check("rnd_miss", {16'd0, ret_miss_cnt}, {16'd0, m_miss});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
